monitor_verdict_collector: RTL and testbench
============================================

Name: monitor_verdict_collector

Overview:
- Sits downstream of the generated RTLola monitor `topEntity` and consumes its stream outputs.
- Inputs are the output values `outA` and `outB`, each qualified by its activation flag `aktvOutA` / `aktvOutB`.
- Every activated output is captured as a record {stream id, timestamp, value} into an internal FIFO.
- Records are drained over a valid/ready interface toward a logger or host link, replacing ad-hoc waveform inspection of monitor verdicts.

Parameters:
- DEPTH, 16, FIFO capacity in records; power of two, >= 2.
- TS_W, 32, timestamp counter width in bits.
- CNT_W, 16, width of drop counter.

Ports:
- clk  in  1  system clock, same domain as monitor.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture/timestamp enable (same `en` fed to monitor).
- out_a  in  64  signed value of stream A.
- aktv_out_a  in  1  stream A produced a value this cycle.
- out_b  in  64  signed value of stream B.
- aktv_out_b  in  1  stream B produced a value this cycle.
- rec_valid  out  1  record available on rec_*.
- rec_ready  in  1  consumer accepts record.
- rec_stream  out  1  0 = stream A, 1 = stream B.
- rec_time  out  TS_W  timestamp of record.
- rec_value  out  64  signed captured value.
- level  out  clog2(DEPTH)+1  records currently stored.
- overflow  out  1  sticky, at least one record dropped since reset.
- drop_count  out  CNT_W  records dropped, saturating.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, timestamp counter=0, level=0.
  - rec_valid=0, overflow=0, drop_count=0.
  - rec_stream/rec_time/rec_value=0.
  - A reset mid-stream discards all stored records; no partial record is emitted.
- Timestamp:
  - Counter increments by 1 each cycle with en=1 and holds when en=0.
  - Wraps modulo 2^TS_W without flagging.
- Capture (only when en=1):
  - Each asserted aktv flag yields one record stamped with the counter value of that cycle, before the increment.
  - If both flags are asserted in the same cycle, A is written first, then B, at consecutive slots.
  - When en=0, aktv flags are ignored.
- Free space per cycle = DEPTH - level + (rec_valid & rec_ready); a same-cycle pop frees a slot.
- Insufficient space:
  - 0 free: every requested record is dropped.
  - 1 free with both A and B requested: A is stored, B is dropped.
  - Each dropped record increments drop_count by 1 (saturating at 2^CNT_W-1) and sets overflow.
  - Stored records are never overwritten.
- Output:
  - First-word-fall-through; rec_* are registered.
  - A record captured at posedge N is visible with rec_valid=1 after posedge N (cycle N+1), if the FIFO was empty.
  - rec_valid = (level != 0).
  - Transfer occurs when rec_valid & rec_ready at a posedge; the next record is presented in the following cycle without bubble.
  - rec_* stay stable while rec_valid=1 and rec_ready=0.
- Draining is independent of en.
- level updates every cycle as level + pushes - pop, where pushes is 0..2 and pop is 0..1.
- Pointers wrap modulo DEPTH.
- Whenever rec_valid=0, rec_stream/rec_time/rec_value are held at their last transferred value; the bench must not check them.

Optional Feature:
- COLLECTOR_TIMESTAMP_EN
  - Defined: timestamp counter is implemented as above and rec_time carries the captured count.
  - Undefined: counter and timestamp storage are omitted; rec_time is tied to 0; all other behaviour is unchanged.

Test Plan:
- Single capture: after reset, hold en=1, pulse aktv_out_a with out_a=5 at counter=10, rec_ready=1 -> one cycle later rec_valid=1, rec_stream=0, rec_value=5, rec_time=10; level returns 0 after transfer.
- Simultaneous capture: assert aktv_out_a (out_a=-3) and aktv_out_b (out_b=7) in the same cycle, rec_ready=1 -> two consecutive records (A,-3,t) then (B,7,t) with the same rec_time t; level peaks at 2.
- Backpressure/full: rec_ready=0, issue 17 single A captures with values 1..17 (DEPTH=16) -> level=16, overflow=1, drop_count=1; releasing ready drains values 1..16 in order.
- Partial space: fill to level=15, rec_ready=0, pulse A=100 and B=200 together -> A stored, B dropped, level=16, drop_count increments by 1.
- Pop frees slot: level=16, rec_ready=1, pulse A=42 in the same cycle -> no drop, level stays 16, 42 is the last record drained.
- en and reset: en=0 with aktv_out_a pulsed -> no record and counter frozen. Then assert rst with level=5 -> next cycle level=0, rec_valid=0, overflow=0, counter=0.

Source files
------------

// File: rtl/monitor_verdict_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : monitor_verdict_collector                                    |
// | Description : Captures activated monitor outputs (A/B) as stamped records  |
// |               into a FIFO, drained first-word-fall-through over rec_*.     |
// |               Optional macro COLLECTOR_TIMESTAMP_EN enables timestamping.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module monitor_verdict_collector #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [63:0]                out_a,
    input  logic                       aktv_out_a,
    input  logic [63:0]                out_b,
    input  logic                       aktv_out_b,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic                       rec_stream,
    output logic [TS_W-1:0]            rec_time,
    output logic [63:0]                rec_value,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [63:0]        r_mem_value  [DEPTH];
    logic               r_mem_stream [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_count;
    logic               r_rec_stream;
    logic [63:0]        r_rec_value;

    logic               w_pop;
    logic               w_req_a;
    logic               w_req_b;
    logic [c_LVL_W-1:0] w_free;
    logic               w_store_a;
    logic               w_store_b;
    logic [1:0]         w_drops;
    logic [c_PTR_W-1:0] w_wr_ptr_b;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_LVL_W-1:0] w_remain;
    logic               w_head_from_mem;
    logic               w_head_from_new;
    logic [CNT_W:0]     w_cnt_sum;

    always_comb begin
        w_pop        = rec_valid & rec_ready;
        w_req_a      = en & aktv_out_a;
        w_req_b      = en & aktv_out_b;
        // A slot popped this cycle is reusable by a same-cycle capture.
        w_free       = c_LVL_W'(DEPTH) - r_level + c_LVL_W'(w_pop);
        w_store_a    = w_req_a && (w_free != '0);
        w_store_b    = w_req_b && (w_free > c_LVL_W'(w_store_a));
        w_drops      = 2'(w_req_a & ~w_store_a) + 2'(w_req_b & ~w_store_b);
        w_wr_ptr_b   = r_wr_ptr + c_PTR_W'(w_store_a);
        w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);
        w_remain     = r_level - c_LVL_W'(w_pop);
        // Next head comes from storage if anything remains, else from this cycle's capture.
        w_head_from_mem = (w_remain != '0);
        w_head_from_new = !w_head_from_mem && (w_store_a || w_store_b);
        w_cnt_sum    = {1'b0, r_drop_count} + (CNT_W+1)'(w_drops);
    end

    always_ff @(posedge clk) begin
        if (w_store_a) begin
            r_mem_value[r_wr_ptr]  <= out_a;
            r_mem_stream[r_wr_ptr] <= 1'b0;
        end
        if (w_store_b) begin
            r_mem_value[w_wr_ptr_b]  <= out_b;
            r_mem_stream[w_wr_ptr_b] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            r_rec_stream <= 1'b0;
            r_rec_value  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_b + c_PTR_W'(w_store_b);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= r_level + c_LVL_W'(w_store_a) + c_LVL_W'(w_store_b) - c_LVL_W'(w_pop);
            if (w_drops != 2'd0) begin
                r_overflow   <= 1'b1;
                r_drop_count <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
            end
            if (w_head_from_mem) begin
                r_rec_stream <= r_mem_stream[w_rd_ptr_nxt];
                r_rec_value  <= r_mem_value[w_rd_ptr_nxt];
            end else if (w_head_from_new) begin
                r_rec_stream <= !w_store_a;
                r_rec_value  <= w_store_a ? out_a : out_b;
            end
        end
    end

`ifdef COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem_time [DEPTH];
    logic [TS_W-1:0] r_rec_time;

    always_ff @(posedge clk) begin
        if (w_store_a) r_mem_time[r_wr_ptr]   <= r_ts;
        if (w_store_b) r_mem_time[w_wr_ptr_b] <= r_ts;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts       <= '0;
            r_rec_time <= '0;
        end else begin
            if (en) r_ts <= r_ts + TS_W'(1);
            if (w_head_from_mem)      r_rec_time <= r_mem_time[w_rd_ptr_nxt];
            else if (w_head_from_new) r_rec_time <= r_ts;
        end
    end

    assign rec_time = r_rec_time;
`else
    assign rec_time = '0;
`endif

    assign rec_valid  = (r_level != '0);
    assign rec_stream = r_rec_stream;
    assign rec_value  = r_rec_value;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_monitor_verdict_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_monitor_verdict_collector                                 |
// | Description : Self-checking bench for monitor_verdict_collector: vector    |
// |               table, directed corner sequences and a queue-based model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_monitor_verdict_collector;

    localparam int DEPTH = 16;
    localparam int TS_W  = 32;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [63:0]       out_a = '0;
    logic              aktv_out_a = 1'b0;
    logic [63:0]       out_b = '0;
    logic              aktv_out_b = 1'b0;
    logic              rec_valid;
    logic              rec_ready = 1'b0;
    logic              rec_stream;
    logic [TS_W-1:0]   rec_time;
    logic [63:0]       rec_value;
    logic [4:0]        level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;

    monitor_verdict_collector #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .out_a(out_a), .aktv_out_a(aktv_out_a),
        .out_b(out_b), .aktv_out_b(aktv_out_b),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_stream(rec_stream), .rec_time(rec_time), .rec_value(rec_value),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stream;
        logic [31:0] tstamp;
        logic [63:0] value;
    } rec_t;

    rec_t        m_q[$];
    logic [31:0] m_ts;
    logic        m_ovf;
    logic [15:0] m_drops;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] exp_time(input logic [31:0] t);
`ifdef COLLECTOR_TIMESTAMP_EN
        return t;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_drop();
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops++;
    endtask

    task automatic check_model();
        chk("valid", 64'(rec_valid), 64'(m_q.size() != 0));
        chk("level", 64'(level), 64'(m_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        if (m_q.size() != 0) begin
            chk("stream", 64'(rec_stream), 64'(m_q[0].stream));
            chk("value", rec_value, m_q[0].value);
            chk("time", 64'(rec_time), 64'(exp_time(m_q[0].tstamp)));
        end
    endtask

    // Apply one cycle of inputs (at negedge), check, advance model, clock.
    task automatic step(input logic e, input logic aa, input logic [63:0] a,
                        input logic ab, input logic [63:0] b, input logic rdy);
        rec_t r;
        en = e; aktv_out_a = aa; out_a = a; aktv_out_b = ab; out_b = b; rec_ready = rdy;
        check_model();
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (e) begin
            if (aa) begin
                if (m_q.size() < DEPTH) begin
                    r.stream = 1'b0; r.tstamp = m_ts; r.value = a; m_q.push_back(r);
                end else model_drop();
            end
            if (ab) begin
                if (m_q.size() < DEPTH) begin
                    r.stream = 1'b1; r.tstamp = m_ts; r.value = b; m_q.push_back(r);
                end else model_drop();
            end
            m_ts++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; aktv_out_a = 1'b0; aktv_out_b = 1'b0; rec_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete(); m_ts = '0; m_ovf = 1'b0; m_drops = '0;
    endtask

    typedef struct {
        logic        e, aa;
        logic [63:0] a;
        logic        ab;
        logic [63:0] b;
        logic        rdy;
        logic        x_valid;
        logic [4:0]  x_level;
        logic        x_stream;
        logic [63:0] x_value;
        logic [31:0] x_time;
    } vec_t;

    vec_t tbl[15];

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 32'd0};
        tbl[10] = '{1'b1, 1'b1, 64'd5, 1'b0, 64'd0, 1'b1, 1'b1, 5'd1, 1'b0, 64'd5, 32'd10};
        tbl[11] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 32'd0};
        tbl[12] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 64'd7, 1'b1,
                    1'b1, 5'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 32'd12};
        tbl[13] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 5'd1, 1'b1, 64'd7, 32'd12};
        tbl[14] = '{1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0, 64'd0, 32'd0};

        @(negedge clk);
        do_reset();
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        chk("rst_stream", 64'(rec_stream), 64'd0);
        chk("rst_time", 64'(rec_time), 64'd0);
        chk("rst_value", rec_value, 64'd0);

        // Single and simultaneous capture vectors
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].e, tbl[i].aa, tbl[i].a, tbl[i].ab, tbl[i].b, tbl[i].rdy);
            chk("tbl_valid", 64'(rec_valid), 64'(tbl[i].x_valid));
            chk("tbl_level", 64'(level), 64'(tbl[i].x_level));
            if (tbl[i].x_valid) begin
                chk("tbl_stream", 64'(rec_stream), 64'(tbl[i].x_stream));
                chk("tbl_value", rec_value, tbl[i].x_value);
                chk("tbl_time", 64'(rec_time), 64'(exp_time(tbl[i].x_time)));
            end
        end

        // Backpressure: 17 captures into 16 slots
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 64'd0, 1'b0);
        chk("full_level", 64'(level), 64'd16);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_drops", 64'(drop_count), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_value", rec_value, 64'(i));
            step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        end
        chk("drain_empty", 64'(rec_valid), 64'd0);

        // Partial space, then pop frees a slot
        do_reset();
        for (int i = 1; i <= 15; i++) step(1'b1, 1'b1, 64'(i), 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b1, 64'd100, 1'b1, 64'd200, 1'b0);
        chk("part_level", 64'(level), 64'd16);
        chk("part_drops", 64'(drop_count), 64'd1);
        step(1'b1, 1'b1, 64'd42, 1'b0, 64'd0, 1'b1);
        chk("popfree_level", 64'(level), 64'd16);
        chk("popfree_drops", 64'(drop_count), 64'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 14) chk("part_a_kept", rec_value, 64'd100);
            if (i == 15) chk("last_is_42", rec_value, 64'd42);
            step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        end

        // en gating, then reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'd9, 1'b0, 64'd0, 1'b1);
        chk("en0_level", 64'(level), 64'd0);
        step(1'b1, 1'b1, 64'd9, 1'b0, 64'd0, 1'b0);
        chk("en0_frozen_time", 64'(rec_time), 64'(exp_time(32'd0)));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'd10 + 64'(i), 1'b0, 64'd0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd5);
        do_reset();
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(rec_valid), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        step(1'b1, 1'b1, 64'd77, 1'b0, 64'd0, 1'b0);
        chk("mid_rst_counter", 64'(rec_time), 64'(exp_time(32'd0)));

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, {$urandom, $urandom},
                 $urandom_range(0, 2) == 0, {$urandom, $urandom},
                 $urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 30 : 80));
        end
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
